ofdm_cp_remover: RTL and testbench

- Sits directly downstream of the Schmidl-Cox detector.
- Consumes the timing-aligned, oversampled OFDM packet stream that the detector emits. In that stream, tlast marks the end of each OFDM packet.
- Per symbol, it strips the cyclic prefix and decimates the FFT window by the oversampling factor.
- Emits exactly FFT_SIZE samples per symbol, framed with tlast, for the downstream FFT.

---
 rtl/ofdm_cp_remover.sv | 196 +++++++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_remover.sv
// Strips the OFDM cyclic prefix per symbol and decimates the FFT window to FFT_SIZE samples.
// Latency: 1 cycle from accepted input sample to o_tvalid (single registered output stage).
// Backpressure: i_tready follows the output stage (empty or draining); held low while zero-padding a cut-short symbol.
module ofdm_cp_remover #(
  parameter int FFT_SIZE     = 1024,
  parameter int CP_SIZE      = 128,
  parameter int OVERSAMPLING = 5,
  localparam int BW = $clog2(CP_SIZE * OVERSAMPLING + 1),
  localparam int PW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [BW-1:0] cp_backoff,
  input  logic [PW-1:0] decim_phase,
  input  logic [31:0]   i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          i_tready,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic          o_pkt_done,
  output logic [15:0]   o_sym_count
);

  localparam int CPI = CP_SIZE * OVERSAMPLING;
  localparam int FWI = FFT_SIZE * OVERSAMPLING;
  localparam int CW  = $clog2(CPI + FWI);
  localparam int OW  = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;

  typedef enum logic [1:0] {ST_CP, ST_BODY, ST_TAIL, ST_PAD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, in_cnt_nxt;
  logic [PW-1:0] ph_cnt, ph_cnt_nxt;
  logic [OW-1:0] out_idx, out_idx_nxt;
  logic [BW-1:0] cfg_bo, cfg_bo_nxt;
  logic [PW-1:0] cfg_ph, cfg_ph_nxt;
  logic          cfg_pend, cfg_pend_nxt;
  logic          pad_fin, pad_fin_nxt;
  logic          sym_clr, sym_clr_nxt;
  logic [31:0]   tdata_nxt;
  logic          tlast_nxt, tvalid_nxt, pkt_done_nxt;
  logic [15:0]   sym_nxt;
  logic          out_free, in_acc, in_body, idx_last, body_last, cp_last, tail_last;
  logic          pkt_end, sym_inc, emit;
  logic [BW-1:0] cur_bo;
  logic [PW-1:0] cur_ph;
  logic [CW-1:0] cp_len;

  assign out_free  = !o_tvalid || o_tready;
  assign i_tready  = (state != ST_PAD) && out_free;
  assign in_acc    = i_tvalid && i_tready;

  // Effective configuration: clamped port values on a packet's first sample, latched copy afterwards.
  always_comb begin
    cur_bo = cfg_bo;
    cur_ph = cfg_ph;
    if (cfg_pend) begin
      cur_bo = (int'(cp_backoff) > CPI) ? BW'(CPI) : cp_backoff;
      cur_ph = (int'(decim_phase) >= OVERSAMPLING) ? PW'(OVERSAMPLING - 1) : decim_phase;
    end
  end

  // A zero-length discard region means the CP state behaves as the first BODY sample.
  assign cp_len    = CW'(CPI) - CW'(cur_bo);
  assign in_body   = (state == ST_BODY) || ((state == ST_CP) && (cp_len == '0));
  assign idx_last  = (out_idx == OW'(FFT_SIZE - 1));
  assign body_last = (in_cnt == CW'(FWI - 1));
  assign cp_last   = (in_cnt == cp_len - 1'b1);
  assign tail_last = (in_cnt == CW'(cur_bo) - 1'b1);

  // Next-state, counter and output-stage logic.
  always_comb begin
    state_nxt    = state;
    in_cnt_nxt   = in_cnt;
    ph_cnt_nxt   = ph_cnt;
    out_idx_nxt  = out_idx;
    cfg_bo_nxt   = cfg_bo;
    cfg_ph_nxt   = cfg_ph;
    cfg_pend_nxt = cfg_pend;
    pad_fin_nxt  = pad_fin;
    sym_clr_nxt  = 1'b0;
    tdata_nxt    = o_tdata;
    tlast_nxt    = o_tlast;
    tvalid_nxt   = o_tvalid && !o_tready;
    pkt_done_nxt = 1'b0;
    pkt_end      = 1'b0;
    sym_inc      = 1'b0;
    emit         = 1'b0;

    if (in_acc) begin
      if (cfg_pend) begin
        cfg_pend_nxt = 1'b0;
        cfg_bo_nxt   = cur_bo;
        cfg_ph_nxt   = cur_ph;
      end
      if (in_body) begin
        emit       = (ph_cnt == cur_ph);
        ph_cnt_nxt = (ph_cnt == PW'(OVERSAMPLING - 1)) ? '0 : ph_cnt + 1'b1;
        in_cnt_nxt = in_cnt + 1'b1;
        state_nxt  = ST_BODY;
        if (emit) begin
          tdata_nxt   = i_tdata;
          tvalid_nxt  = 1'b1;
          tlast_nxt   = idx_last;
          out_idx_nxt = idx_last ? '0 : out_idx + 1'b1;
          sym_inc     = idx_last;
        end
        if (body_last) begin
          in_cnt_nxt = '0;
          ph_cnt_nxt = '0;
          state_nxt  = (cur_bo != '0) ? ST_TAIL : ST_CP;
          pkt_end    = i_tlast;
        end else if (i_tlast) begin
          // Symbol cut short: pad with zeros unless this sample already closed it.
          state_nxt   = ST_PAD;
          pad_fin_nxt = emit && idx_last;
        end
      end else if (state == ST_CP) begin
        in_cnt_nxt = cp_last ? '0 : in_cnt + 1'b1;
        state_nxt  = cp_last ? ST_BODY : ST_CP;
        pkt_end    = i_tlast;
      end else begin
        in_cnt_nxt = tail_last ? '0 : in_cnt + 1'b1;
        state_nxt  = tail_last ? ST_CP : ST_TAIL;
        pkt_end    = i_tlast;
      end
    end else if (state == ST_PAD) begin
      if (!pad_fin) begin
        if (out_free) begin
          tdata_nxt   = '0;
          tvalid_nxt  = 1'b1;
          tlast_nxt   = idx_last;
          out_idx_nxt = idx_last ? '0 : out_idx + 1'b1;
          sym_inc     = idx_last;
          pad_fin_nxt = idx_last;
        end
      end else if (o_tvalid && o_tready) begin
        pkt_end = 1'b1;
      end
    end

    if (pkt_end) begin
      state_nxt    = ST_CP;
      in_cnt_nxt   = '0;
      ph_cnt_nxt   = '0;
      out_idx_nxt  = '0;
      pad_fin_nxt  = 1'b0;
      cfg_pend_nxt = 1'b1;
      pkt_done_nxt = 1'b1;
      sym_clr_nxt  = 1'b1;
    end

    // The count stays visible during the done pulse and clears the cycle after.
    sym_nxt = (sym_clr ? 16'd0 : o_sym_count) + 16'(sym_inc);
  end

  // State and datapath registers; reset or clear abandons any partial symbol.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= ST_CP;
      in_cnt      <= '0;
      ph_cnt      <= '0;
      out_idx     <= '0;
      cfg_bo      <= '0;
      cfg_ph      <= '0;
      cfg_pend    <= 1'b1;
      pad_fin     <= 1'b0;
      sym_clr     <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_sym_count <= '0;
    end else begin
      state       <= state_nxt;
      in_cnt      <= in_cnt_nxt;
      ph_cnt      <= ph_cnt_nxt;
      out_idx     <= out_idx_nxt;
      cfg_bo      <= cfg_bo_nxt;
      cfg_ph      <= cfg_ph_nxt;
      cfg_pend    <= cfg_pend_nxt;
      pad_fin     <= pad_fin_nxt;
      sym_clr     <= sym_clr_nxt;
      o_tdata     <= tdata_nxt;
      o_tlast     <= tlast_nxt;
      o_tvalid    <= tvalid_nxt;
      o_pkt_done  <= pkt_done_nxt;
      o_sym_count <= sym_nxt;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Bench for ofdm_cp_remover: directed ramps plus random packets against a per-packet reference model.
// Latency: outputs are scored in order from an expected queue, independent of cycle timing.
// Backpressure: o_tready is optionally randomised and stalled outputs must hold.
`timescale 1ns/1ps
module tb_ofdm_cp_remover;

  localparam int FFT = 8;
  localparam int CPS = 2;
  localparam int OS  = 2;
  localparam int CPI = CPS * OS;
  localparam int FWI = FFT * OS;
  localparam int SYM = CPI + FWI;
  localparam int BW  = $clog2(CPI + 1);
  localparam int PW  = (OS > 1) ? $clog2(OS) : 1;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [BW-1:0] cp_backoff;
  logic [PW-1:0] decim_phase;
  logic [31:0]   i_tdata;
  logic          i_tlast, i_tvalid, i_tready;
  logic [31:0]   o_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic          o_pkt_done;
  logic [15:0]   o_sym_count;

  always #5 clk = ~clk;

  ofdm_cp_remover #(.FFT_SIZE(FFT), .CP_SIZE(CPS), .OVERSAMPLING(OS)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cp_backoff(cp_backoff), .decim_phase(decim_phase),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_pkt_done(o_pkt_done), .o_sym_count(o_sym_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  int          exp_done[$];
  bit          rdy_rand = 1'b0;
  bit          pad_watch = 1'b0;
  int          done_seen = 0;
  int          ends_sent = 0;
  logic [32:0] e_mon;
  logic        stall_q = 1'b0;
  logic [32:0] held_q = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position within packet -> CP / window / tail by plain arithmetic.
  task automatic model(input logic [31:0] d[$], input int bo_raw, input int ph_raw, input bit ends);
    int   bo, ph, cpl, n, syms, r, b;
    logic l;
    bo = bo_raw % (1 << BW);
    ph = ph_raw % (1 << PW);
    if (bo > CPI) bo = CPI;
    if (ph > OS - 1) ph = OS - 1;
    cpl = CPI - bo;
    n = 0; syms = 0; r = 0;
    for (int p = 0; p < d.size(); p++) begin
      r = p % SYM;
      if (r == 0) n = 0;
      if (r >= cpl && r < cpl + FWI) begin
        b = r - cpl;
        if (b % OS == ph) begin
          l = (n == FFT - 1);
          exp_q.push_back({l, d[p]});
          if (l) syms++;
          n++;
        end
      end
    end
    if (ends) begin
      if (r >= cpl && r < cpl + FWI && (r - cpl) != FWI - 1) begin
        for (int k = n; k < FFT; k++) begin
          l = (k == FFT - 1);
          exp_q.push_back({l, 32'h0});
          if (l) syms++;
        end
      end
      exp_done.push_back(syms);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("push_timeout", {31'd0, i_tready}, 32'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int bo, input int ph, input bit ramp,
                          input bit ends, input int gap_pct, input bit watch);
    logic [31:0] d[$];
    for (int i = 0; i < len; i++) d.push_back(ramp ? 32'(i) : $urandom());
    model(d, bo, ph, ends);
    if (ends) ends_sent++;
    cp_backoff  = BW'(bo);
    decim_phase = PW'(ph);
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      push(d[i], ends && (i == len - 1));
    end
    if (watch) pad_watch = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_done.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + exp_done.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("sym_cleared", {16'd0, o_sym_count}, 32'd0);
    chk("done_low", {31'd0, o_pkt_done}, 32'd0);
  endtask

  task automatic abort_mid_symbol(input bit use_clear);
    send_pkt(11, 0, 0, 1'b1, 1'b0, 0, 1'b0);
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; clear = 1'b0;
    chk("abort_vld", {31'd0, o_tvalid}, 32'd0);
    chk("abort_sym", {16'd0, o_sym_count}, 32'd0);
    chk("abort_leftover", 32'(exp_q.size()), 32'd0);
    send_pkt(20, 0, 0, 1'b1, 1'b1, 0, 1'b0);
    drain();
  endtask

  // Output ready driver.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output scoreboard, stall-hold check and packet-done tracking.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_q) begin
        chk("hold_vld", {31'd0, o_tvalid}, 32'd1);
        chk("hold_dat", o_tdata, held_q[31:0]);
        chk("hold_last", {31'd0, o_tlast}, {31'd0, held_q[32]});
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) chk("unexpected_out", o_tdata, 32'hDEAD_BEEF);
        else begin
          e_mon = exp_q.pop_front();
          chk("out_data", o_tdata, e_mon[31:0]);
          chk("out_last", {31'd0, o_tlast}, {31'd0, e_mon[32]});
        end
      end
      if (o_pkt_done) begin
        done_seen++;
        pad_watch = 1'b0;
        if (exp_done.size() == 0) chk("spurious_done", {31'd0, o_pkt_done}, 32'd0);
        else chk("sym_count", {16'd0, o_sym_count}, 32'(exp_done.pop_front()));
      end else if (pad_watch) begin
        chk("pad_rdy", {31'd0, i_tready}, 32'd0);
      end
      stall_q = o_tvalid && !o_tready && !reset && !clear;
      held_q  = {o_tlast, o_tdata};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; clear = 1'b0;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
    cp_backoff = '0; decim_phase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", {31'd0, o_tvalid}, 32'd0);
    chk("rst_last", {31'd0, o_tlast}, 32'd0);
    chk("rst_data", o_tdata, 32'd0);
    chk("rst_done", {31'd0, o_pkt_done}, 32'd0);
    chk("rst_sym", {16'd0, o_sym_count}, 32'd0);
    chk("rst_rdy", {31'd0, i_tready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two full symbols.
    d0 = done_seen;
    send_pkt(40, 0, 0, 1'b1, 1'b1, 0, 1'b0);
    drain();
    chk("s1_done_once", 32'(done_seen - d0), 32'd1);

    // Backoff and phase with tail discard.
    send_pkt(20, 2, 1, 1'b1, 1'b1, 0, 1'b0);
    drain();

    // Mid-symbol packet end -> zero padding.
    send_pkt(10, 0, 0, 1'b1, 1'b1, 0, 1'b1);
    drain();

    // Random backpressure.
    rdy_rand = 1'b1;
    send_pkt(40, 0, 0, 1'b1, 1'b1, 0, 1'b0);
    drain();
    rdy_rand = 1'b0;

    // Out-of-range configuration is clamped.
    send_pkt(20, 7, 3, 1'b1, 1'b1, 0, 1'b0);
    drain();

    // Reset, then clear, in the middle of a symbol.
    abort_mid_symbol(1'b0);
    abort_mid_symbol(1'b1);

    // Random packets back to back, random data, gaps and backpressure.
    for (int p = 0; p < 25; p++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      send_pkt($urandom_range(1, 70), $urandom_range(0, 7), $urandom_range(0, 1),
               1'b0, 1'b1, 20, 1'b0);
    end
    drain();
    rdy_rand = 1'b0;

    chk("done_total", 32'(done_seen), 32'(ends_sent));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
